// File: rtl/split_slave_ctrl.sv
// split_slave_ctrl
//   Slave-side sequencer for a split-capable slave on the system bus.
//   It takes one bus transaction at a time and forwards it to a slow backing
//   memory. If the memory is too slow, the bus is released with a split. The
//   bus is re-requested once the data is back, and the transaction completes
//   when the arbiter regrants it.
//
// Ports
//   clk, rst            : clock and synchronous active-high reset
//   req_valid           : 1-cycle transaction start strobe (accepted in IDLE only)
//   req_write/addr/wdata: transaction attributes, sampled with req_valid
//   split_grant         : arbiter pulse regranting the split owner (RESUME only)
//   mem_ack, mem_rdata  : memory completion pulse and read data
//   mem_req             : 1-cycle memory request pulse
//   mem_we/addr/wdata   : latched transaction, held until the next request
//   ssplit, sreadysp    : split / split-ready indications to the arbiter
//   busy                : high whenever the sequencer is not IDLE
//   resp_valid/rdata    : 1-cycle completion pulse and read data (0 for writes)
//   timeout_err         : 1-cycle pulse when a resume is abandoned
//
// Handshake: every strobe input (req_valid, mem_ack, split_grant) is a
// single-cycle pulse. It is acted on only in the states that expect it and is
// otherwise dropped. Nothing is queued. All outputs are registered and show
// the state that was entered at the previous clock edge.

module split_slave_ctrl #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 8,
    parameter int SPLIT_THRESH   = 4,
    parameter int RESUME_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              split_grant,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              ssplit,
    output logic              sreadysp,
    output logic              busy,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              timeout_err
);

    typedef enum logic [2:0] {IDLE, WAIT, SPLIT, RESUME, RESP} state_t;

    localparam int CNT_MAX = (SPLIT_THRESH > RESUME_TIMEOUT) ? SPLIT_THRESH : RESUME_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] SPLIT_LAST  = CNT_W'(SPLIT_THRESH - 1);
    localparam logic [CNT_W-1:0] RESUME_LAST = CNT_W'(RESUME_TIMEOUT - 1);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next, cnt_inc;
    logic               mem_req_next, mem_we_next;
    logic [ADDR_W-1:0]  mem_addr_next;
    logic [DATA_W-1:0]  mem_wdata_next, resp_rdata_next;
    logic               ssplit_next, sreadysp_next, busy_next;
    logic               resp_valid_next, timeout_next;

    // Saturating count: it never wraps back into a range that looks like a fresh wait.
    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            ssplit      <= 1'b0;
            sreadysp    <= 1'b1;
            busy        <= 1'b0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            mem_req     <= mem_req_next;
            mem_we      <= mem_we_next;
            mem_addr    <= mem_addr_next;
            mem_wdata   <= mem_wdata_next;
            ssplit      <= ssplit_next;
            sreadysp    <= sreadysp_next;
            busy        <= busy_next;
            resp_valid  <= resp_valid_next;
            resp_rdata  <= resp_rdata_next;
            timeout_err <= timeout_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (req_valid) state_next = WAIT;
            // An ack arriving on the last allowed cycle beats the split.
            WAIT: begin
                if (mem_ack)                  state_next = RESP;
                else if (cnt >= SPLIT_LAST)   state_next = SPLIT;
            end
            SPLIT:  if (mem_ack) state_next = RESUME;
            // A grant arriving on the timeout cycle beats the abort.
            RESUME: begin
                if (split_grant)              state_next = RESP;
                else if (cnt >= RESUME_LAST)  state_next = IDLE;
            end
            RESP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values for the registered outputs
    always_comb begin
        cnt_next        = cnt;
        mem_req_next    = 1'b0;
        mem_we_next     = mem_we;
        mem_addr_next   = mem_addr;
        mem_wdata_next  = mem_wdata;
        resp_rdata_next = resp_rdata;
        timeout_next    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    mem_req_next   = 1'b1;
                    mem_we_next    = req_write;
                    mem_addr_next  = req_addr;
                    mem_wdata_next = req_wdata;
                    cnt_next       = '0;
                end
            end
            WAIT: begin
                cnt_next = cnt_inc;
                if (mem_ack) resp_rdata_next = mem_we ? '0 : mem_rdata;
            end
            SPLIT: begin
                if (mem_ack) begin
                    resp_rdata_next = mem_we ? '0 : mem_rdata;
                    cnt_next        = '0;
                end
            end
            RESUME: begin
                cnt_next = cnt_inc;
                if (!split_grant && cnt >= RESUME_LAST) timeout_next = 1'b1;
            end
            default: ;
        endcase
        // Arbiter-facing levels follow the state being entered.
        resp_valid_next = (state_next == RESP);
        busy_next       = (state_next != IDLE);
        ssplit_next     = (state_next == SPLIT);
        sreadysp_next   = !((state_next == WAIT) || (state_next == SPLIT));
    end

endmodule

// File: tb/tb_split_slave_ctrl.sv
module tb_split_slave_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, split_grant, mem_ack;
    logic [11:0] req_addr;
    logic [7:0]  req_wdata, mem_rdata;
    logic        mem_req, mem_we, ssplit, sreadysp, busy, resp_valid, timeout_err;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata, resp_rdata;

    int compared   = 0;
    int mismatched = 0;

    // Pulse monitors, sampled on the falling edge
    int resp_pulses    = 0;
    int mem_req_pulses = 0;
    int ssplit_seen    = 0;

    split_slave_ctrl #(
        .ADDR_W(12), .DATA_W(8), .SPLIT_THRESH(4), .RESUME_TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .split_grant(split_grant), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .ssplit(ssplit),
        .sreadysp(sreadysp), .busy(busy), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .timeout_err(timeout_err)
    );

    // Clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid) resp_pulses++;
            if (mem_req)    mem_req_pulses++;
            if (ssplit)     ssplit_seen++;
        end
    end

    // Advance one cycle; outputs are read 1 time unit after the edge and
    // inputs changed then are sampled at the following edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic wr, input logic [11:0] a, input logic [7:0] d);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        compared++; if (sreadysp !== 1'b1) begin mismatched++; $display("FAIL reset_sreadysp got=%b exp=1", sreadysp); end
        compared++; if (ssplit !== 1'b0) begin mismatched++; $display("FAIL reset_ssplit got=%b exp=0", ssplit); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got=%b exp=0", busy); end
        compared++; if (resp_valid !== 1'b0) begin mismatched++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_fast_read();
        int s0;
        s0 = ssplit_seen;
        issue(1'b0, 12'h0A5, 8'h00);
        step(1);                                   // first WAIT cycle
        req_valid = 1'b0;
        compared++; if (mem_req !== 1'b1) begin mismatched++; $display("FAIL fast_mem_req got=%b exp=1", mem_req); end
        compared++; if (mem_addr !== 12'h0A5) begin mismatched++; $display("FAIL fast_mem_addr got=%h exp=0a5", mem_addr); end
        compared++; if (mem_we !== 1'b0) begin mismatched++; $display("FAIL fast_mem_we got=%b exp=0", mem_we); end
        compared++; if ({busy, sreadysp} !== 2'b10) begin mismatched++; $display("FAIL fast_wait_flags got=%b exp=10", {busy, sreadysp}); end
        step(1);
        compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL fast_mem_req_pulse got=%b exp=0", mem_req); end
        step(1);                                   // 2 cycles after mem_req
        mem_ack = 1'b1; mem_rdata = 8'h3C;
        step(1);                                   // d+2 = 4 cycles after req
        mem_ack = 1'b0; mem_rdata = 8'h00;
        compared++; if (resp_valid !== 1'b1) begin mismatched++; $display("FAIL fast_resp_valid got=%b exp=1", resp_valid); end
        compared++; if (resp_rdata !== 8'h3C) begin mismatched++; $display("FAIL fast_resp_rdata got=%h exp=3c", resp_rdata); end
        compared++; if ({ssplit, sreadysp} !== 2'b01) begin mismatched++; $display("FAIL fast_resp_flags got=%b exp=01", {ssplit, sreadysp}); end
        step(1);
        compared++; if ({resp_valid, busy} !== 2'b00) begin mismatched++; $display("FAIL fast_done got=%b exp=00", {resp_valid, busy}); end
        compared++; if (ssplit_seen != s0) begin mismatched++; $display("FAIL fast_no_split got=%0d exp=%0d", ssplit_seen, s0); end
    endtask

    task automatic test_split_read();
        issue(1'b0, 12'h123, 8'h00);
        step(1);                                   // WAIT cnt=0
        req_valid = 1'b0;
        step(3);                                   // 4th WAIT cycle
        compared++; if (ssplit !== 1'b0) begin mismatched++; $display("FAIL split_wait4_ssplit got=%b exp=0", ssplit); end
        step(1);
        compared++; if ({ssplit, sreadysp} !== 2'b10) begin mismatched++; $display("FAIL split_enter got=%b exp=10", {ssplit, sreadysp}); end
        step(6);                                   // 10 cycles after mem_req
        compared++; if (ssplit !== 1'b1) begin mismatched++; $display("FAIL split_hold got=%b exp=1", ssplit); end
        mem_ack = 1'b1; mem_rdata = 8'h5A;
        step(1);                                   // RESUME
        mem_ack = 1'b0; mem_rdata = 8'h00;
        compared++; if ({ssplit, sreadysp, busy, resp_valid} !== 4'b0110) begin mismatched++; $display("FAIL split_resume got=%b exp=0110", {ssplit, sreadysp, busy, resp_valid}); end
        step(2);                                   // 3 cycles after the ack
        split_grant = 1'b1;
        step(1);
        split_grant = 1'b0;
        compared++; if (resp_valid !== 1'b1) begin mismatched++; $display("FAIL split_resp_valid got=%b exp=1", resp_valid); end
        compared++; if (resp_rdata !== 8'h5A) begin mismatched++; $display("FAIL split_resp_rdata got=%h exp=5a", resp_rdata); end
        step(1);
        compared++; if ({resp_valid, busy, ssplit} !== 3'b000) begin mismatched++; $display("FAIL split_done got=%b exp=000", {resp_valid, busy, ssplit}); end
    endtask

    task automatic test_boundary();
        int r0;
        int m0;
        m0 = mem_req_pulses;
        issue(1'b0, 12'h0F0, 8'h00);
        step(1);                                   // WAIT cnt=0
        req_valid = 1'b0;
        step(1);                                   // WAIT cnt=1: stray request
        issue(1'b1, 12'h321, 8'hEE);
        step(1);                                   // WAIT cnt=2
        req_valid = 1'b0;
        compared++; if ({mem_addr, mem_we} !== {12'h0F0, 1'b0}) begin mismatched++; $display("FAIL bnd_ignored_req got=%h/%b exp=0f0/0", mem_addr, mem_we); end
        step(1);                                   // WAIT cnt=3: ack on last cycle
        mem_ack = 1'b1; mem_rdata = 8'h77;
        r0 = resp_pulses;
        step(1);
        mem_ack = 1'b0; mem_rdata = 8'h00;
        compared++; if ({resp_valid, ssplit} !== 2'b10) begin mismatched++; $display("FAIL bnd_resp got=%b exp=10", {resp_valid, ssplit}); end
        compared++; if (resp_rdata !== 8'h77) begin mismatched++; $display("FAIL bnd_rdata got=%h exp=77", resp_rdata); end
        step(1);
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL bnd_busy got=%b exp=0", busy); end
        compared++; if (mem_req_pulses != m0 + 1) begin mismatched++; $display("FAIL bnd_mem_req_count got=%0d exp=%0d", mem_req_pulses, m0 + 1); end
        compared++; if (resp_pulses != r0 + 1) begin mismatched++; $display("FAIL bnd_resp_count got=%0d exp=%0d", resp_pulses, r0 + 1); end
        compared++; if (mem_addr !== 12'h0F0) begin mismatched++; $display("FAIL bnd_addr_hold got=%h exp=0f0", mem_addr); end
    endtask

    task automatic test_resume_timeout();
        int r0;
        int early;
        r0 = resp_pulses;
        early = 0;
        issue(1'b0, 12'h200, 8'h00);
        step(1);
        req_valid = 1'b0;
        step(4);                                   // SPLIT
        mem_ack = 1'b1; mem_rdata = 8'h11;
        step(1);                                   // RESUME cnt=0
        mem_ack = 1'b0; mem_rdata = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (timeout_err !== 1'b0 || busy !== 1'b1) early++;
            if (i < 7) step(1);
        end
        compared++; if (early != 0) begin mismatched++; $display("FAIL to_early_exit got=%0d exp=0", early); end
        step(1);
        compared++; if (timeout_err !== 1'b1) begin mismatched++; $display("FAIL to_pulse got=%b exp=1", timeout_err); end
        compared++; if ({busy, resp_valid, sreadysp} !== 3'b001) begin mismatched++; $display("FAIL to_idle got=%b exp=001", {busy, resp_valid, sreadysp}); end
        split_grant = 1'b1;                        // late grant
        step(1);
        split_grant = 1'b0;
        compared++; if (timeout_err !== 1'b0) begin mismatched++; $display("FAIL to_single_pulse got=%b exp=0", timeout_err); end
        step(1);
        compared++; if ({resp_valid, busy} !== 2'b00) begin mismatched++; $display("FAIL to_late_grant got=%b exp=00", {resp_valid, busy}); end
        compared++; if (resp_pulses != r0) begin mismatched++; $display("FAIL to_no_resp got=%0d exp=%0d", resp_pulses, r0); end
    endtask

    task automatic test_reset_mid_split();
        int r0;
        issue(1'b0, 12'h3AB, 8'h00);
        step(1);
        req_valid = 1'b0;
        step(4);
        compared++; if (ssplit !== 1'b1) begin mismatched++; $display("FAIL rst_pre_ssplit got=%b exp=1", ssplit); end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        compared++; if ({sreadysp, ssplit, mem_req, mem_we, busy, resp_valid, timeout_err} !== 7'b1000000) begin mismatched++; $display("FAIL rst_mid_flags got=%b exp=1000000", {sreadysp, ssplit, mem_req, mem_we, busy, resp_valid, timeout_err}); end
        compared++; if ({mem_addr, mem_wdata, resp_rdata} !== 28'h0) begin mismatched++; $display("FAIL rst_mid_data got=%h exp=0000000", {mem_addr, mem_wdata, resp_rdata}); end
        r0 = resp_pulses;
        mem_ack = 1'b1; mem_rdata = 8'h99;         // stale ack in IDLE
        step(1);
        mem_ack = 1'b0; mem_rdata = 8'h00;
        step(1);
        compared++; if ({resp_valid, busy} !== 2'b00) begin mismatched++; $display("FAIL rst_stale_ack got=%b exp=00", {resp_valid, busy}); end
        compared++; if (resp_pulses != r0) begin mismatched++; $display("FAIL rst_stale_count got=%0d exp=%0d", resp_pulses, r0); end
        issue(1'b1, 12'h001, 8'hFF);
        step(1);
        req_valid = 1'b0;
        compared++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 12'h001, 8'hFF}) begin mismatched++; $display("FAIL wr_mem_if got=%b/%b/%h/%h exp=1/1/001/ff", mem_req, mem_we, mem_addr, mem_wdata); end
        mem_ack = 1'b1; mem_rdata = 8'hAB;         // ack with mem_req, d=0
        step(1);
        mem_ack = 1'b0; mem_rdata = 8'h00;
        compared++; if ({resp_valid, resp_rdata} !== {1'b1, 8'h00}) begin mismatched++; $display("FAIL wr_resp got=%b/%h exp=1/00", resp_valid, resp_rdata); end
        step(1);
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL wr_done_busy got=%b exp=0", busy); end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; split_grant = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        test_reset();
        test_fast_read();
        test_split_read();
        test_boundary();
        test_resume_timeout();
        test_reset_mid_split();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/split_slave_ctrl.md
Name: split_slave_ctrl

Overview:
Slave-side sequencer for the split-capable slave on the serial system bus.
- Accepts one bus transaction at a time and forwards it to a slow backing memory.
- Drives ssplit and sreadysp toward the bus arbiter.
- If the memory does not answer within SPLIT_THRESH cycles, it releases the bus with a split. When the memory data arrives, it re-requests the bus and completes the transaction after the arbiter returns split_grant.

Parameters:
ADDR_W, 12, transaction/memory address width
DATA_W, 8, data width
SPLIT_THRESH, 4, cycles waited for mem_ack before splitting (>=1)
RESUME_TIMEOUT, 64, cycles in RESUME without split_grant before abort (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  transaction start strobe from bus slave port, 1 cycle
req_write  in  1  1=write, 0=read; sampled with req_valid
req_addr  in  ADDR_W  transaction address; sampled with req_valid
req_wdata  in  DATA_W  write data; sampled with req_valid
split_grant  in  1  arbiter pulse: split owner regranted
mem_ack  in  1  backing memory completion, 1-cycle pulse
mem_rdata  in  DATA_W  read data, valid with mem_ack
mem_req  out  1  1-cycle memory request pulse
mem_we  out  1  memory write enable, held with mem_addr
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
ssplit  out  1  split indication to arbiter
sreadysp  out  1  split slave ready to arbiter
busy  out  1  high in every state except IDLE
resp_valid  out  1  1-cycle transaction-complete pulse
resp_rdata  out  DATA_W  read data, valid with resp_valid (0 for writes)
timeout_err  out  1  1-cycle pulse on resume abort

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, cnt=0, sreadysp=1, ssplit=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, resp_valid=0, resp_rdata=0, timeout_err=0.
- Reset mid-operation returns to IDLE with these values. Any pending memory response is dropped, and a later mem_ack is ignored in IDLE.
- States: IDLE, WAIT, SPLIT, RESUME, RESP.
- IDLE: sreadysp=1, ssplit=0.
  - On req_valid: latch write/addr/wdata onto mem_we/mem_addr/mem_wdata, pulse mem_req for exactly 1 cycle, cnt<=0, go to WAIT.
  - mem_req is high in the first WAIT cycle.
- WAIT: sreadysp=0, ssplit=0; cnt increments each cycle.
  - mem_ack while cnt<SPLIT_THRESH: latch mem_rdata (0 for a write) into resp_rdata, go to RESP. This is the no-split fast path.
  - No ack when cnt==SPLIT_THRESH-1: go to SPLIT. ssplit=1 from the next cycle.
  - mem_ack on that same cycle takes priority: go to RESP, no split.
- SPLIT: ssplit=1, sreadysp=0.
  - Wait indefinitely for mem_ack.
  - On mem_ack: latch rdata, cnt<=0, go to RESUME.
- RESUME: ssplit=0, sreadysp=1; cnt increments.
  - split_grant: go to RESP.
  - No grant when cnt==RESUME_TIMEOUT-1: pulse timeout_err, go to IDLE, no resp_valid.
  - split_grant and timeout on the same cycle: grant wins.
- RESP: resp_valid=1 for 1 cycle, resp_rdata held; next state IDLE. sreadysp=1 and ssplit=0 in RESP.
- Ignored inputs:
  - req_valid in any state other than IDLE (no queueing).
  - split_grant outside RESUME.
  - mem_ack outside WAIT/SPLIT.
- mem_addr, mem_we and mem_wdata hold their latched values until the next accepted request.
- cnt width is clog2(max(SPLIT_THRESH,RESUME_TIMEOUT)+1) and saturates, never wraps.
- Latency, request to resp_valid:
  - Fast path: ack delay d cycles after mem_req (d<SPLIT_THRESH) gives resp_valid d+2 cycles after the req_valid cycle.
  - Split path: set by mem_ack and split_grant timing.

Test Plan:
1. Reset, SPLIT_THRESH=4: assert rst 2 cycles -> sreadysp=1, ssplit=0, busy=0, resp_valid=0, mem_req=0.
2. Fast read: req_valid, addr=0x0A5; mem_ack with rdata=0x3C 2 cycles after mem_req -> mem_req 1 cycle with mem_addr=0x0A5, mem_we=0; ssplit never 1; resp_valid 1 cycle with resp_rdata=0x3C; busy back to 0.
3. Split read: mem_ack 10 cycles after mem_req (rdata=0x5A) -> ssplit=1 after 4 WAIT cycles; after ack ssplit=0, sreadysp=1; split_grant 3 cycles later -> resp_valid with 0x5A on the cycle after split_grant.
4. Boundary: mem_ack exactly at cnt==3 -> no split, resp_valid next cycle. Also, req_valid during WAIT with a different addr -> ignored, mem_addr unchanged.
5. Resume timeout, RESUME_TIMEOUT=8: split then ack, no split_grant -> timeout_err pulses after 8 RESUME cycles, no resp_valid, busy=0. A late split_grant is then ignored.
6. Reset mid-SPLIT: rst while ssplit=1 -> all outputs at reset values next cycle. A following mem_ack causes no resp_valid; a new write (addr=0x001, wdata=0xFF) then completes normally with mem_we=1.
